// File: rtl/pdm_decimator.sv
// PDM microphone front end: generates the mic clock, counts ones per window
// (first-order CIC) and emits unsigned offset-binary PCM words.
module pdm_decimator #(
   parameter int unsigned WORD_LENGTH        = 16,
   parameter int unsigned SYSTEM_FREQUENCY   = 100000000,
   parameter int unsigned SAMPLING_FREQUENCY = 1000000,
   parameter int unsigned DECIMATION         = 64,
   parameter int unsigned SETTLE_WINDOWS     = 2
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   pdm_data_i,
   output logic                   pdm_clk_o,
   output logic [WORD_LENGTH-1:0] data_o,
   output logic                   done_o,
   output logic                   clipped_o
);

   localparam int unsigned CLK_DIV = SYSTEM_FREQUENCY / (2 * SAMPLING_FREQUENCY);
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W   = $clog2(DECIMATION);
   localparam int unsigned ACC_W   = BIT_W + 1;
   localparam int unsigned SET_W   = (SETTLE_WINDOWS > 0) ? $clog2(SETTLE_WINDOWS + 1) : 1;
   localparam int unsigned SHIFT   = WORD_LENGTH - BIT_W;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DECIMATION - 1);
   localparam logic [ACC_W-1:0] ACC_FULL   = ACC_W'(DECIMATION);
   localparam logic [SET_W-1:0] SET_TARGET = SET_W'(SETTLE_WINDOWS);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   logic [1:0]             state_q,      state_d;
   logic [DIV_W-1:0]       div_cnt_q,    div_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q,    bit_cnt_d;
   logic [ACC_W-1:0]       ones_acc_q,   ones_acc_d;
   logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
   logic                   pdm_clk_q,    pdm_clk_d;
   logic [WORD_LENGTH-1:0] data_q,       data_d;
   logic                   done_q,       done_d;
   logic                   clipped_q,    clipped_d;

   logic [ACC_W-1:0]       total_ones;
   logic [WORD_LENGTH:0]   scaled;
   logic [WORD_LENGTH-1:0] sat_word;
   logic [SET_W-1:0]       settle_next;
   logic                   bit_sample;
   logic                   window_end;

   // The bit being sampled closes the window, so it is folded into the total.
   assign total_ones  = ones_acc_q + ACC_W'(pdm_data_i);
   assign scaled      = (WORD_LENGTH + 1)'(total_ones) << SHIFT;
   assign sat_word    = scaled[WORD_LENGTH] ? '1 : scaled[WORD_LENGTH-1:0];
   assign settle_next = settle_cnt_q + 1'b1;
   assign bit_sample  = pdm_clk_q && (div_cnt_q == DIV_LAST);
   assign window_end  = bit_sample && (bit_cnt_q == BIT_LAST);

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      ones_acc_d   = ones_acc_q;
      settle_cnt_d = settle_cnt_q;
      pdm_clk_d    = pdm_clk_q;
      data_d       = data_q;
      done_d       = 1'b0;
      clipped_d    = clipped_q;

      case (state_q)
         ST_IDLE: begin
            div_cnt_d    = '0;
            bit_cnt_d    = '0;
            ones_acc_d   = '0;
            settle_cnt_d = '0;
            pdm_clk_d    = 1'b0;
            if (enable_i) begin
               clipped_d = 1'b0;
               state_d   = (SETTLE_WINDOWS == 0) ? ST_RUN : ST_SETTLE;
            end
         end

         ST_SETTLE, ST_RUN: begin
            if (!enable_i) begin
               // Dropping enable discards everything, including a window closing now.
               state_d      = ST_IDLE;
               div_cnt_d    = '0;
               bit_cnt_d    = '0;
               ones_acc_d   = '0;
               settle_cnt_d = '0;
               pdm_clk_d    = 1'b0;
            end else begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_d = '0;
                  pdm_clk_d = ~pdm_clk_q;
               end else begin
                  div_cnt_d = div_cnt_q + 1'b1;
               end

               if (bit_sample) begin
                  if (window_end) begin
                     bit_cnt_d  = '0;
                     ones_acc_d = '0;
                  end else begin
                     bit_cnt_d  = bit_cnt_q + 1'b1;
                     ones_acc_d = total_ones;
                  end
               end

               if (window_end) begin
                  if (state_q == ST_SETTLE) begin
                     settle_cnt_d = settle_next;
                     if (settle_next == SET_TARGET) begin
                        state_d = ST_RUN;
                     end
                  end else begin
                     data_d = sat_word;
                     done_d = 1'b1;
                     if ((total_ones == '0) || (total_ones == ACC_FULL)) begin
                        clipped_d = 1'b1;
                     end
                  end
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            pdm_clk_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         ones_acc_q   <= '0;
         settle_cnt_q <= '0;
         pdm_clk_q    <= 1'b0;
         data_q       <= '0;
         done_q       <= 1'b0;
         clipped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         ones_acc_q   <= ones_acc_d;
         settle_cnt_q <= settle_cnt_d;
         pdm_clk_q    <= pdm_clk_d;
         data_q       <= data_d;
         done_q       <= done_d;
         clipped_q    <= clipped_d;
      end
   end

   assign pdm_clk_o = pdm_clk_q;
   assign data_o    = data_q;
   assign done_o    = done_q;
   assign clipped_o = clipped_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Scoreboard bench for pdm_decimator: the driver predicts each PCM word from
// window popcounts; a negedge monitor checks every done_o pulse against it.
module tb_pdm_decimator;

   localparam int CD  = 5;            // clock divider for the bench configuration
   localparam int D   = 16;           // PDM bits per window
   localparam int WL  = 16;
   localparam int SW  = 2;
   localparam int WIN = 2 * CD * D;   // cycles per window

   typedef struct {
      longint     cyc;
      logic [15:0] data;
      logic        clip;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          pdm_data;
   logic          pdm_clk;
   logic [WL-1:0] data;
   logic          done;
   logic          clipped;

   longint        cyc = 0;
   int            n_cmp = 0;
   int            n_bad = 0;
   exp_t          exp_q[$];
   logic [15:0]   held_exp = '0;
   logic          clip_exp = 1'b0;

   pdm_decimator #(
      .WORD_LENGTH       (WL),
      .SYSTEM_FREQUENCY  (2 * CD * 1000000),
      .SAMPLING_FREQUENCY(1000000),
      .DECIMATION        (D),
      .SETTLE_WINDOWS    (SW)
   ) dut (
      .clock_i   (clk),
      .reset_i   (reset),
      .enable_i  (enable),
      .pdm_data_i(pdm_data),
      .pdm_clk_o (pdm_clk),
      .data_o    (data),
      .done_o    (done),
      .clipped_o (clipped)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
      end
   endtask

   // Monitor: every done_o pulse must match the oldest predicted word.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done at cycle %0d: got data 0x%0h, expected no pulse", cyc, data);
         end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("done_data", longint'(data), longint'(e.data));
            chk("done_clip", longint'(clipped), longint'(e.clip));
         end
      end
   end

   // pat: 0 zeros, 1 ones, 2 alternating, 3 one-in-four, 4 random.
   // Enable is high for cycles 0..ncyc; cycle ncyc+1 drops enable (or pulses reset).
   task automatic session(input int pat, input int ncyc, input bit end_reset);
      bit     bits[$];
      int     nbits;
      int     ones;
      int     val;
      int     w;
      longint base;
      logic   clip_sess;
      logic   exp_clk;

      nbits = ncyc / (2 * CD) + 4;
      for (int k = 0; k < nbits; k++) begin
         case (pat)
            0:       bits.push_back(1'b0);
            1:       bits.push_back(1'b1);
            2:       bits.push_back((k % 2) == 0);
            3:       bits.push_back((k % 4) == 0);
            default: bits.push_back($urandom_range(0, 1) == 1);
         endcase
      end
      clip_sess = 1'b0;

      @(posedge clk);
      #1;
      enable   = 1'b1;
      pdm_data = 1'b0;
      base     = cyc;

      for (int t = 1; t <= ncyc + 6; t++) begin
         @(posedge clk);
         #1;
         if (t == ncyc + 1) begin
            enable = 1'b0;
            if (end_reset) reset = 1'b1;
         end
         if (t == ncyc + 2) reset = 1'b0;
         pdm_data = bits[(t - 1) / (2 * CD)];

         exp_clk = (t <= ncyc + 1) ? (((t - 1) / CD) % 2 == 1) : 1'b0;
         chk("pdm_clk", longint'(pdm_clk), longint'(exp_clk));

         if (t == 1) begin
            chk("clip_cleared", longint'(clipped), 0);
            chk("data_held_enable", longint'(data), longint'(held_exp));
         end

         if (t <= ncyc && (t % WIN) == 0) begin
            w = t / WIN - 1;
            if (w >= SW) begin
               ones = 0;
               for (int k = w * D; k < (w + 1) * D; k++) ones += int'(bits[k]);
               val = ones * (65536 / D);
               if (val > 65535) val = 65535;
               if (ones == 0 || ones == D) clip_sess = 1'b1;
               exp_q.push_back('{base + t + 1, 16'(val), clip_sess});
               held_exp = 16'(val);
            end
         end

         if (t == ncyc + 2) begin
            if (end_reset) begin
               held_exp = '0;
               clip_exp = 1'b0;
               chk("reset_data", longint'(data), 0);
               chk("reset_done", longint'(done), 0);
               chk("reset_clip", longint'(clipped), 0);
            end else begin
               clip_exp = clip_sess;
               chk("idle_data_held", longint'(data), longint'(held_exp));
               chk("idle_clip_held", longint'(clipped), longint'(clip_exp));
            end
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      pdm_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pdm_clk", longint'(pdm_clk), 0);
      chk("rst_data", longint'(data), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_clip", longint'(clipped), 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("idle_pdm_clk", longint'(pdm_clk), 0);
      end

      session(0, 3 * WIN + 10, 1'b0);            // silence: first word 0x0000, clipped
      session(2, 5 * WIN + 50, 1'b1);            // half density 0x8000, reset mid-window
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("post_reset_pdm_clk", longint'(pdm_clk), 0);
      end
      session(1, 2 * CD * (4 * D + 10), 1'b0);   // saturation, abort partway through a window
      session(3, 13 * WIN - 1, 1'b0);            // ten quarter-density words, drop at a window close
      session(4, 6 * WIN + 3, 1'b0);             // random density

      repeat (2 * WIN) @(posedge clk);
      #1;
      chk("pending_done", longint'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pdm_decimator.md
# pdm_decimator

Audio capture front end: drives the PDM microphone clock, samples the 1-bit PDM stream and decimates it with a boxcar (first-order CIC) filter into unsigned offset-binary PCM words. Sits directly upstream of the clip memory write port, replacing the raw bit-packing capture stage. Each new word is announced by `done_o`, which drives the sample counter and the timer tick.

## Interface
- WORD_LENGTH, 16, PCM output width in bits
- SYSTEM_FREQUENCY, 100000000, clock_i frequency in Hz
- SAMPLING_FREQUENCY, 1000000, pdm_clk_o frequency in Hz; CLK_DIV = SYSTEM_FREQUENCY/(2*SAMPLING_FREQUENCY), default 50
- DECIMATION, 64, PDM bits per output word; power of two, 2..2^WORD_LENGTH
- SETTLE_WINDOWS, 2, windows discarded after each enable rise (mic start-up)

Ports:
- clock_i  in  1  system clock, 100 MHz
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  capture enable from controller
- pdm_data_i  in  1  PDM data from microphone (lrsel tied high at top level)
- pdm_clk_o  out  1  PDM clock to microphone
- data_o  out  WORD_LENGTH  last decimated sample
- done_o  out  1  one-cycle pulse: data_o just updated
- clipped_o  out  1  sticky: a window was all ones or all zeros

## Operation
- Registers: div_cnt (0..CLK_DIV-1), bit_cnt (0..DECIMATION-1), ones_acc (0..DECIMATION, log2(DECIMATION)+1 bits), settle_cnt, pdm_clk_o, data_o, done_o, clipped_o.
- States: IDLE, SETTLE, RUN.
- IDLE: all counters 0, pdm_clk_o=0, done_o=0; data_o holds. enable_i=1 -> SETTLE, settle_cnt=0, clipped_o cleared in the same cycle.
- Divider (SETTLE/RUN): div_cnt increments each cycle; at CLK_DIV-1 it wraps to 0 and pdm_clk_o toggles.
- Bit sample: in the cycle where pdm_clk_o=1 and div_cnt=CLK_DIV-1 (end of high phase), pdm_data_i is added to ones_acc and bit_cnt increments.
- Window end (bit_cnt=DECIMATION-1 at a sample): ones_acc and bit_cnt restart from 0, the new sample bit becoming the last bit of the closed window.
  - SETTLE: settle_cnt increments; at SETTLE_WINDOWS -> RUN. No done_o, data_o unchanged, clipped_o unchanged.
  - RUN: data_o <= min(total_ones << (WORD_LENGTH - log2(DECIMATION)), 2^WORD_LENGTH-1); done_o=1 for one cycle; clipped_o <= 1 if total_ones is 0 or DECIMATION.
- Arithmetic: unsigned; all-ones window saturates to 0xFFFF; all-zeros gives 0x0000; half gives 0x8000 (WORD_LENGTH=16).
- enable_i=0 in SETTLE/RUN: next cycle IDLE, partial window discarded, no done_o, pdm_clk_o=0. A window completing in the same cycle enable_i falls is discarded.
- Re-enable always restarts settle; nothing is carried across enable cycles.
- reset_i has priority over everything: IDLE, all registers 0, including data_o and clipped_o.

## Timing
- Reset values: pdm_clk_o=0, data_o=0, done_o=0, clipped_o=0.
- Cycle 0 = first cycle enable_i=1 is seen in IDLE (state -> SETTLE at edge ending cycle 0; divider starts at cycle 1).
- pdm_clk_o first rises at cycle CLK_DIV+1; period 2*CLK_DIV cycles, 50% duty.
- Bit k (from 0) is sampled at cycle 2*CLK_DIV*(k+1).
- Window w closes at bit DECIMATION*(w+1)-1; done_o and data_o are visible the following cycle. Defaults: 6400 cycles per window; first done_o at cycle 19201, then every 6400 cycles.
- done_o never asserts on two consecutive cycles; max rate one per 2*CLK_DIV*DECIMATION cycles.
- Latency from last window bit sample to data_o: 1 cycle.

## Test plan
- Reset: assert reset_i mid-RUN with data_o=0x8000 -> next cycle data_o=0, done_o=0, clipped_o=0, pdm_clk_o=0, no pdm_clk_o edges while enable_i=0.
- Clock/settle: enable_i=1 held, pdm_data_i=0 -> pdm_clk_o period 100 cycles; first rise at cycle 51; no done_o before cycle 19201; done_o at 19201 with data_o=0x0000, clipped_o=1.
- Levels: pdm_data_i constant 1 -> data_o=0xFFFF (saturated), clipped_o=1; alternating 1/0 per PDM bit -> data_o=0x8000, clipped_o=0; 16 ones per 64 bits -> 0x4000.
- Abort: drop enable_i at bit 40 of a RUN window -> no done_o, pdm_clk_o low next cycle; re-enable -> clipped_o cleared, 2 windows discarded, next done_o 19201 cycles after re-enable.
- Periodicity: 10 windows in RUN -> exactly 10 single-cycle done_o pulses spaced 6400 cycles.
- Window boundary: toggle enable_i low in the exact cycle a window closes -> no done_o, data_o unchanged.
